// File: rtl/lod_shifter_in_mul_div_pkg.sv
// Shared definitions for the input-side log encoder of the SIMD
// approximate multiplier-divider.
package lod_shifter_in_mul_div_pkg;

  // Operand lane split: one full-width lane or two half-width lanes.
  typedef enum logic {
    MODE_FULL = 1'b0,
    MODE_SIMD = 1'b1
  } mode_e;

  localparam int N_DEFAULT   = 16;
  localparam int LGN_DEFAULT = 4;

  // Fraction widths once the leading one has been stripped.
  function automatic int full_frac_w(input int n);
    return n - 1;
  endfunction

  function automatic int lane_frac_w(input int n);
    return n / 2 - 1;
  endfunction

endpackage

// File: rtl/lod_lane.sv
// One encoder lane: leading-one detector on the incoming operand and
// normalizing left shift on the operand/index captured one stage later.
module lod_lane #(
  parameter int W  = 16,
  parameter int KW = $clog2(W)
) (
  input  logic [W-1:0]  a_i,
  output logic [KW-1:0] k_o,
  output logic          zero_o,
  input  logic [W-1:0]  norm_a_i,
  input  logic [KW-1:0] norm_k_i,
  output logic [W-2:0]  frac_o
);

  logic [KW-1:0] shamt;

  // Priority encoder: the last (highest) set bit wins; zero operand yields 0.
  always_comb begin
    k_o = '0;
    for (int i = 0; i < W; i++) begin
      if (a_i[i]) k_o = i[KW-1:0];
    end
  end

  assign zero_o = ~|a_i;

  // Shift the leading one up to bit W-1, then drop it; bits below are the fraction.
  always_comb begin
    shamt  = KW'(W - 1) - norm_k_i;
    frac_o = (W-1)'(norm_a_i << shamt);
  end

endmodule

// File: rtl/lod_shifter_in_mul_div.sv
// Input-side log encoder: characteristic and left-aligned fraction per lane,
// two-stage pipeline (detect, then normalize) with valid/ready on both sides.
module lod_shifter_in_mul_div
  import lod_shifter_in_mul_div_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int lgN = LGN_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           mode,
  input  logic [N-1:0]   a,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_mode,
  output logic [lgN-1:0] k_upper,
  output logic [lgN-2:0] k_lower,
  output logic [N-1:0]   frac,
  output logic           zero_upper,
  output logic           zero_lower
);

  localparam int H  = N / 2;
  localparam int FW = full_frac_w(N);
  localparam int LW = lane_frac_w(N);

  logic           s1_valid_q;
  mode_e          s1_mode_q;
  logic [N-1:0]   s1_a_q;
  logic [lgN-1:0] s1_kf_q;
  logic [lgN-2:0] s1_kh_q, s1_kl_q;
  logic           s1_zf_q, s1_zh_q, s1_zl_q;

  logic           out_valid_q, out_mode_q, zero_upper_q, zero_lower_q;
  logic [lgN-1:0] k_upper_q;
  logic [lgN-2:0] k_lower_q;
  logic [N-1:0]   frac_q;

  logic [lgN-1:0] k_full, k_upper_d;
  logic [lgN-2:0] k_hi, k_lo, k_lower_d;
  logic           z_full, z_hi, z_lo, zero_upper_d, zero_lower_d;
  logic [FW-1:0]  frac_full;
  logic [LW-1:0]  frac_hi, frac_lo;
  logic [N-1:0]   frac_d;
  logic           s1_load, s2_load;

  lod_lane #(.W(N), .KW(lgN)) u_full (
    .a_i(a), .k_o(k_full), .zero_o(z_full),
    .norm_a_i(s1_a_q), .norm_k_i(s1_kf_q), .frac_o(frac_full)
  );

  lod_lane #(.W(H), .KW(lgN-1)) u_hi (
    .a_i(a[N-1:H]), .k_o(k_hi), .zero_o(z_hi),
    .norm_a_i(s1_a_q[N-1:H]), .norm_k_i(s1_kh_q), .frac_o(frac_hi)
  );

  lod_lane #(.W(H), .KW(lgN-1)) u_lo (
    .a_i(a[H-1:0]), .k_o(k_lo), .zero_o(z_lo),
    .norm_a_i(s1_a_q[H-1:0]), .norm_k_i(s1_kl_q), .frac_o(frac_lo)
  );

  assign s2_load  = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // Stage 1: capture operand, mode and all leading-one candidates.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= MODE_FULL;
      s1_a_q     <= '0;
      s1_kf_q    <= '0;
      s1_kh_q    <= '0;
      s1_kl_q    <= '0;
      s1_zf_q    <= 1'b0;
      s1_zh_q    <= 1'b0;
      s1_zl_q    <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_mode_q <= mode_e'(mode);
        s1_a_q    <= a;
        s1_kf_q   <= k_full;
        s1_kh_q   <= k_hi;
        s1_kl_q   <= k_lo;
        s1_zf_q   <= z_full;
        s1_zh_q   <= z_hi;
        s1_zl_q   <= z_lo;
      end
    end
  end

  // Mode mux: pick full-lane or SIMD lane results and pack the fraction word.
  always_comb begin
    k_upper_d    = '0;
    k_lower_d    = '0;
    frac_d       = '0;
    zero_upper_d = 1'b0;
    zero_lower_d = 1'b0;
    if (s1_mode_q == MODE_SIMD) begin
      k_upper_d    = {1'b0, s1_kh_q};
      k_lower_d    = s1_kl_q;
      frac_d       = {1'b0, frac_hi, 1'b0, frac_lo};
      zero_upper_d = s1_zh_q;
      zero_lower_d = s1_zl_q;
    end else begin
      k_upper_d    = s1_kf_q;
      frac_d       = {1'b0, frac_full};
      zero_upper_d = s1_zf_q;
    end
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_mode_q   <= 1'b0;
      k_upper_q    <= '0;
      k_lower_q    <= '0;
      frac_q       <= '0;
      zero_upper_q <= 1'b0;
      zero_lower_q <= 1'b0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_mode_q   <= s1_mode_q;
        k_upper_q    <= k_upper_d;
        k_lower_q    <= k_lower_d;
        frac_q       <= frac_d;
        zero_upper_q <= zero_upper_d;
        zero_lower_q <= zero_lower_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_mode   = out_mode_q;
  assign k_upper    = k_upper_q;
  assign k_lower    = k_lower_q;
  assign frac       = frac_q;
  assign zero_upper = zero_upper_q;
  assign zero_lower = zero_lower_q;

endmodule

// File: tb/tb_lod_shifter_in_mul_div.sv
module tb_lod_shifter_in_mul_div;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, mode, out_valid, out_ready, out_mode;
  logic        zero_upper, zero_lower;
  logic [15:0] a, frac;
  logic [3:0]  k_upper;
  logic [2:0]  k_lower;

  typedef struct packed {
    logic        m;
    logic [3:0]  ku;
    logic [2:0]  kl;
    logic [15:0] fr;
    logic        zu;
    logic        zl;
  } res_t;

  res_t sbq[$];
  res_t mon_exp, mon_got;
  int   checks = 0;
  int   errors = 0;

  lod_shifter_in_mul_div #(.N(16), .lgN(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .a(a), .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .k_upper(k_upper), .k_lower(k_lower), .frac(frac),
    .zero_upper(zero_upper), .zero_lower(zero_lower)
  );

  always #5 clk = ~clk;

  // Reference encoder: scan down from the top for the first one, fraction is
  // (v minus its leading one) shifted so its MSB lands at bit w-2.
  function automatic void enc(input int unsigned v, input int w,
                              output int k, output logic [15:0] f, output logic z);
    z = 1'b1; k = 0; f = '0;
    for (int i = w - 1; i >= 0; i--) begin
      if (z && v[i]) begin z = 1'b0; k = i; end
    end
    if (!z) f = 16'((v - (32'd1 << k)) << (w - 1 - k));
  endfunction

  function automatic res_t model(input logic m, input logic [15:0] v);
    res_t r; int k; logic [15:0] f; logic z;
    r = '0;
    r.m = m;
    if (!m) begin
      enc({16'd0, v}, 16, k, f, z);
      r.ku = 4'(k); r.fr = f; r.zu = z;
    end else begin
      enc({24'd0, v[15:8]}, 8, k, f, z);
      r.ku = 4'(k); r.fr[14:8] = f[6:0]; r.zu = z;
      enc({24'd0, v[7:0]}, 8, k, f, z);
      r.kl = 3'(k); r.fr[6:0] = f[6:0]; r.zl = z;
    end
    return r;
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        checks++;
        mon_got = {out_mode, k_upper, k_lower, frac, zero_upper, zero_lower};
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_output got=%h expected none", mon_got);
        end else begin
          mon_exp = sbq.pop_front();
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL sb_result got m=%b ku=%0d kl=%0d fr=%h zu=%b zl=%b expected m=%b ku=%0d kl=%0d fr=%h zu=%b zl=%b",
                     mon_got.m, mon_got.ku, mon_got.kl, mon_got.fr, mon_got.zu, mon_got.zl,
                     mon_exp.m, mon_exp.ku, mon_exp.kl, mon_exp.fr, mon_exp.zu, mon_exp.zl);
          end
        end
      end
      if (in_valid && in_ready) sbq.push_back(model(mode, a));
    end
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; a = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_mode, k_upper, k_lower, frac, zero_upper, zero_lower} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs got ov=%b ku=%0d kl=%0d fr=%h expected all zero",
               out_valid, k_upper, k_lower, frac);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b expected=1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mode0_basic();
    mode = 1'b0; a = 16'h00B0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || k_upper !== 4'd7 || frac !== 16'h3000 ||
        zero_upper !== 1'b0 || k_lower !== 3'd0) begin
      errors++;
      $display("FAIL mode0_b0 got ov=%b ku=%0d fr=%h zu=%b kl=%0d expected ov=1 ku=7 fr=3000 zu=0 kl=0",
               out_valid, k_upper, frac, zero_upper, k_lower);
    end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    mode = 1'b0; out_ready = 1'b1; a = 16'h8000; in_valid = 1'b1;
    @(posedge clk); #1 a = 16'h0001;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || k_upper !== 4'd15 || frac !== 16'h0000) begin
      errors++;
      $display("FAIL b2b_first got ov=%b ku=%0d fr=%h expected ov=1 ku=15 fr=0000", out_valid, k_upper, frac);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || k_upper !== 4'd0 || frac !== 16'h0000 || zero_upper !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got ov=%b ku=%0d fr=%h zu=%b expected ov=1 ku=0 fr=0000 zu=0",
               out_valid, k_upper, frac, zero_upper);
    end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_simd_and_zero();
    out_ready = 1'b1; in_valid = 1'b1; mode = 1'b1; a = 16'h3A05;
    @(posedge clk); #1 mode = 1'b1; a = 16'h0080;
    @(posedge clk); #1 mode = 1'b0; a = 16'h0000;
    @(negedge clk);
    checks++;
    if (out_mode !== 1'b1 || k_upper !== 4'd5 || k_lower !== 3'd2 || frac !== 16'h6820 ||
        zero_upper !== 1'b0 || zero_lower !== 1'b0) begin
      errors++;
      $display("FAIL simd_3a05 got m=%b ku=%0d kl=%0d fr=%h zu=%b zl=%b expected m=1 ku=5 kl=2 fr=6820 zu=0 zl=0",
               out_mode, k_upper, k_lower, frac, zero_upper, zero_lower);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (zero_upper !== 1'b1 || k_upper !== 4'd0 || k_lower !== 3'd7 || frac !== 16'h0000 ||
        zero_lower !== 1'b0) begin
      errors++;
      $display("FAIL simd_0080 got ku=%0d kl=%0d fr=%h zu=%b zl=%b expected ku=0 kl=7 fr=0000 zu=1 zl=0",
               k_upper, k_lower, frac, zero_upper, zero_lower);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_mode !== 1'b0 || zero_upper !== 1'b1 || k_upper !== 4'd0 || frac !== 16'h0000 ||
        k_lower !== 3'd0 || zero_lower !== 1'b0) begin
      errors++;
      $display("FAIL mode0_zero got m=%b ku=%0d kl=%0d fr=%h zu=%b zl=%b expected m=0 ku=0 kl=0 fr=0000 zu=1 zl=0",
               out_mode, k_upper, k_lower, frac, zero_upper, zero_lower);
    end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [15:0] vals [3];
    logic [3:0]  seen [$];
    int idx;
    vals = '{16'h0003, 16'h0100, 16'h1000};
    idx = 0;
    mode = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (idx < 3) begin in_valid = 1'b1; a = vals[idx]; end
      else in_valid = 1'b0;
      out_ready = (c >= 4);
      @(negedge clk);
      if (c == 2 || c == 3) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || k_upper !== 4'd1 || frac !== 16'h4000) begin
          errors++;
          $display("FAIL bp_stall c=%0d got ir=%b ov=%b ku=%0d fr=%h expected ir=0 ov=1 ku=1 fr=4000",
                   c, in_ready, out_valid, k_upper, frac);
        end
      end
      if (out_valid && out_ready) seen.push_back(k_upper);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (seen.size() != 3 || seen[0] !== 4'd1 || seen[1] !== 4'd8 || seen[2] !== 4'd12) begin
      errors++;
      $display("FAIL bp_order got count=%0d expected count=3 with ku 1,8,12", seen.size());
    end
  endtask

  task automatic test_reset_flush();
    int spurious;
    spurious = 0;
    mode = 1'b0; out_ready = 1'b1; in_valid = 1'b1; a = 16'h0055;
    @(posedge clk); #1 a = 16'h0777;
    @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1; sbq.delete();
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_mode, k_upper, k_lower, frac, zero_upper, zero_lower} !== 27'd0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state got ov=%b ku=%0d kl=%0d fr=%h ir=%b expected all zero ir=1",
               out_valid, k_upper, k_lower, frac, in_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++; $display("FAIL flush_no_ghost got=%0d valid cycles expected=0", spurious);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      mode      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       a = 16'(32'd1 << $urandom_range(0, 15));
        1:       a = 16'($urandom_range(0, 255));
        default: a = 16'($urandom_range(0, 65535));
      endcase
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; a = '0; out_ready = 1'b1;
    test_reset();
    test_mode0_basic();
    test_back_to_back();
    test_simd_and_zero();
    test_backpressure();
    test_reset_flush();
    test_random();
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL sb_leftover got=%0d pending expected=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
